// File: rtl/iram_loader_pkg.sv
// iram_loader_pkg: shared definitions for the instruction-RAM loader.
//   - AW_DEF   : instruction address width, also used by the CPU fetch port and ROM
//   - SYNC_DEF : default frame start byte
//   - state_t  : loader FSM state encoding (3 bits)
//   - add8     : modulo-256 add used for the running frame checksum
package iram_loader_pkg;

  localparam int          AW_DEF   = 14;
  localparam logic [7:0]  SYNC_DEF = 8'hA5;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_AH   = 3'd1,
    ST_AL   = 3'd2,
    ST_LH   = 3'd3,
    ST_LL   = 3'd4,
    ST_DATA = 3'd5,
    ST_CHK  = 3'd6,
    ST_END  = 3'd7
  } state_t;

  // Carry out of bit 7 is deliberately dropped.
  function automatic logic [7:0] add8(input logic [7:0] a, input logic [7:0] b);
    return a + b;
  endfunction

endpackage

// File: rtl/iram_loader_timer.sv
// loader_timer: 16-bit mid-frame idle counter.
//   clk     : clock
//   rst     : synchronous active-high reset, clears the count
//   clr     : clear the count (byte accepted, or not inside a frame)
//   en      : count this cycle (inside a frame, no byte accepted)
//   expired : high in the cycle that would make the TIMEOUT-th consecutive idle
//             cycle, so the FSM aborts on that same clock edge
module loader_timer #(
  parameter int TIMEOUT = 1000
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic expired
);

  logic [15:0] cnt;

  assign expired = en && !clr && (cnt == 16'(TIMEOUT - 1));

  always_ff @(posedge clk) begin
    if (rst || clr)
      cnt <= '0;
    else if (en && !expired)
      cnt <= cnt + 16'd1;
    else if (expired)
      cnt <= '0;
  end

endmodule

// File: rtl/iram_loader.sv
// iram_loader: receives a framed byte stream and writes it into instruction RAM,
// holding the CPU in reset until a frame with a good checksum has been loaded.
// Frame: SYNC, AH, AL, LH, LL, LEN data bytes, CHK.  Start address is {AH,AL}
// truncated to AW bits; the 8-bit sum of AH..CHK must be zero for a good frame.
//   CLK_I      : clock
//   RST_I      : synchronous active-high reset
//   S_DAT_I    : stream byte           S_VLD_I : stream byte valid
//   S_RDY_O    : loader ready (low only in the END cycle and right after reset)
//   W_ADDR_O   : RAM write address     W_DAT_O : RAM write data
//   W_WE_O     : RAM write strobe, one cycle after each accepted data byte
//   CPU_HOLD_O : hold CPU in reset while high
//   DONE_O     : one-cycle pulse when a good frame completes
//   ERR_O      : sticky error (bad checksum or mid-frame timeout)
module iram_loader
  import iram_loader_pkg::*;
#(
  parameter int         AW      = AW_DEF,
  parameter int         DW      = 8,
  parameter logic [7:0] SYNC    = SYNC_DEF,
  parameter int         TIMEOUT = 1000
) (
  input  logic          CLK_I,
  input  logic          RST_I,
  input  logic [DW-1:0] S_DAT_I,
  input  logic          S_VLD_I,
  output logic          S_RDY_O,
  output logic [AW-1:0] W_ADDR_O,
  output logic [DW-1:0] W_DAT_O,
  output logic          W_WE_O,
  output logic          CPU_HOLD_O,
  output logic          DONE_O,
  output logic          ERR_O
);

  state_t      state;
  logic [7:0]  sum;
  logic [7:0]  ah;      // latched address high byte, combined with AL
  logic [7:0]  lh;      // latched length high byte, combined with LL
  logic [15:0] rem;     // data bytes still expected
  logic [AW-1:0] ptr;   // address of the next data byte

  logic accept;
  logic in_frame;
  logic tmo;
  logic [7:0] sum_nx;

  assign accept   = S_VLD_I && S_RDY_O;
  assign in_frame = (state != ST_IDLE) && (state != ST_END);
  assign sum_nx   = add8(sum, S_DAT_I);

  loader_timer #(.TIMEOUT(TIMEOUT)) u_timer (
    .clk     (CLK_I),
    .rst     (RST_I),
    .clr     (accept || !in_frame),
    .en      (in_frame && !accept),
    .expired (tmo)
  );

  always_ff @(posedge CLK_I) begin
    if (RST_I) begin
      state      <= ST_IDLE;
      S_RDY_O    <= 1'b0;
      W_WE_O     <= 1'b0;
      W_ADDR_O   <= '0;
      W_DAT_O    <= '0;
      CPU_HOLD_O <= 1'b1;
      DONE_O     <= 1'b0;
      ERR_O      <= 1'b0;
      sum        <= '0;
      ah         <= '0;
      lh         <= '0;
      rem        <= '0;
      ptr        <= '0;
    end else begin
      W_WE_O  <= 1'b0;
      DONE_O  <= 1'b0;
      S_RDY_O <= 1'b1;
      if (tmo) begin
        // Abort; writes already issued stay in RAM.
        state      <= ST_IDLE;
        ERR_O      <= 1'b1;
        CPU_HOLD_O <= 1'b1;
      end else if (state == ST_END) begin
        state <= ST_IDLE;
      end else if (accept) begin
        case (state)
          ST_IDLE: begin
            if (S_DAT_I == SYNC) begin
              state      <= ST_AH;
              sum        <= '0;
              ERR_O      <= 1'b0;
              CPU_HOLD_O <= 1'b1;
            end
          end
          ST_AH: begin
            ah    <= S_DAT_I;
            sum   <= sum_nx;
            state <= ST_AL;
          end
          ST_AL: begin
            ptr   <= AW'({ah, S_DAT_I});
            sum   <= sum_nx;
            state <= ST_LH;
          end
          ST_LH: begin
            lh    <= S_DAT_I;
            sum   <= sum_nx;
            state <= ST_LL;
          end
          ST_LL: begin
            rem   <= {lh, S_DAT_I};
            sum   <= sum_nx;
            state <= ({lh, S_DAT_I} == 16'd0) ? ST_CHK : ST_DATA;
          end
          ST_DATA: begin
            W_WE_O   <= 1'b1;
            W_ADDR_O <= ptr;
            W_DAT_O  <= S_DAT_I;
            ptr      <= ptr + 1'b1;   // wraps naturally at 2^AW
            sum      <= sum_nx;
            rem      <= rem - 16'd1;
            if (rem == 16'd1)
              state <= ST_CHK;
          end
          ST_CHK: begin
            state   <= ST_END;
            S_RDY_O <= 1'b0;
            if (sum_nx == 8'd0) begin
              DONE_O     <= 1'b1;
              CPU_HOLD_O <= 1'b0;
              ERR_O      <= 1'b0;
            end else begin
              ERR_O      <= 1'b1;
              CPU_HOLD_O <= 1'b1;
            end
          end
          default: state <= ST_IDLE;
        endcase
      end
    end
  end

endmodule

// File: doc/iram_loader.md
Name: iram_loader

Overview:
- Write-side counterpart to the 14-bit-address / 8-bit-data instruction-fetch interface (CPU reads I_ADDR_O/I_DAT_I).
- Accepts a framed byte stream (host/UART side) and writes it into instruction RAM.
- Holds the CPU in reset until a frame with a valid checksum has been loaded.
- Sits beside the instruction memory in the system top, replacing the static ROM image for bring-up.

Parameters:
- AW, 14, instruction address width
- DW, 8, data byte width
- SYNC, 8'hA5, frame start byte
- TIMEOUT, 1000, idle cycles allowed mid-frame before abort (counter is 16 bits wide)

Ports:
- CLK_I  in  1  clock
- RST_I  in  1  reset, synchronous, active-high
- S_DAT_I  in  8  stream byte
- S_VLD_I  in  1  stream byte valid
- S_RDY_O  out  1  loader ready; byte accepted when S_VLD_I && S_RDY_O
- W_ADDR_O  out  14  RAM write address
- W_DAT_O  out  8  RAM write data
- W_WE_O  out  1  RAM write enable, single-cycle pulse
- CPU_HOLD_O  out  1  hold CPU in reset while high
- DONE_O  out  1  one-cycle pulse on good frame
- ERR_O  out  1  sticky error flag (checksum or timeout)

Behaviour:
- Reset (RST_I high at a clock edge) forces the following, regardless of the state it interrupts:
  - state IDLE
  - S_RDY_O=0, W_WE_O=0, W_ADDR_O=0, W_DAT_O=0
  - CPU_HOLD_O=1, DONE_O=0, ERR_O=0
  - sum, length and timeout counters cleared
- S_RDY_O=1 in every state except END; in END it is 0.
- Frame format: SYNC, AH, AL, LH, LL, LEN data bytes, CHK.
  - Start address = {AH[5:0],AL}; AH[7:6] are ignored.
  - LEN = {LH,LL}, 16 bits.
- States and transitions (advance only on an accepted byte):
  - IDLE: byte==SYNC goes to AH; clears sum and ERR_O; sets CPU_HOLD_O=1. Any other byte is discarded.
  - AH -> AL -> LH -> LL: each header byte is added to sum.
  - From LL: LEN==0 goes to CHK; otherwise goes to DATA.
  - DATA: each byte is added to sum and written. After LEN bytes, go to CHK.
  - CHK: go to END. Good when (sum+byte) mod 256 == 0.
  - END (1 cycle):
    - Good frame: DONE_O=1 for this cycle, CPU_HOLD_O=0, ERR_O=0.
    - Bad frame: ERR_O=1 and CPU_HOLD_O stays 1.
    - Then go to IDLE.
- Write timing:
  - Registered; W_WE_O=1 exactly one cycle after each accepted data byte.
  - W_ADDR_O = (start + index) mod 2^14, wrapping from 0x3FFF to 0x0000.
  - W_DAT_O = the accepted byte.
  - No writes for header or checksum bytes.
- Sum arithmetic: 8-bit, modulo 256, overflow discarded.
- Timeout:
  - Counter clears on every accepted byte.
  - It increments each cycle while in AH..CHK with no byte accepted.
  - Reaching TIMEOUT goes to IDLE with ERR_O=1 and CPU_HOLD_O=1.
  - Writes already issued are not undone.
- A SYNC value received mid-frame is treated as data, not as a restart.
- ERR_O stays set until the next accepted SYNC byte in IDLE, or until reset.
- Once released after a good frame, CPU_HOLD_O stays 0 in IDLE. It is re-asserted only by the next accepted SYNC or by reset.

Decomposition:
- Shared include file holds:
  - state encodings: IDLE, AH, AL, LH, LL, DATA, CHK, END (3-bit)
  - SYNC default
  - the address-width define, also used by cpu and rom
- One sub-module: loader_timer, the 16-bit idle counter with clear/enable inputs and an expired output at TIMEOUT.

Test Plan:
- Basic load:
  - Stimulus: A5 00 10 00 03 11 22 33 87, one byte per cycle.
  - Required: writes 0x0010=11, 0x0011=22, 0x0012=33; DONE_O pulses once; CPU_HOLD_O falls in END; ERR_O=0.
- Wrap-around:
  - Stimulus: A5 3F FF 00 02 AA BB 5B.
  - Required: writes 0x3FFF=AA then 0x0000=BB; DONE_O=1.
- Bad checksum:
  - Stimulus: basic frame with CHK=88.
  - Required: three writes still occur; ERR_O=1; DONE_O=0; CPU_HOLD_O=1.
  - Then a good frame clears ERR_O at its SYNC and releases hold.
- Zero length plus noise:
  - Stimulus: noise bytes 00 FF 13, then A5 00 00 00 00 00.
  - Required: noise ignored; no W_WE_O pulses; DONE_O=1.
- Timeout, with TIMEOUT=8:
  - Stimulus: A5 00 10, then S_VLD_I=0 for 8 cycles.
  - Required: return to IDLE; ERR_O=1; CPU_HOLD_O=1; no writes.
- Reset mid-frame:
  - Stimulus: RST_I high for one cycle during DATA after the first data byte.
  - Required: all outputs take their reset values on the next edge; state IDLE; a subsequent good frame loads normally.
